// File: rtl/comp_capture_pkg.sv
// Shared types and helpers for the comparator capture stage.
package comp_capture_pkg;

  // Capture sequencer states.
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // Width of the dropped-word counter.
  localparam int OVF_W = 8;

  // Smallest w with 2**w >= nbits+1; sizes a counter that must reach nbits.
  function automatic int cnt_width(input int nbits);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < (nbits + 1)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/comp_capture_satcnt.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones.
module comp_capture_satcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Count events until the maximum value is reached, then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/comp_capture.sv
// Comparator decision capture: assembles NBITS strobed decisions (MSB first)
// into a tagged word on a one-entry valid/ready output register and counts
// words lost to back-pressure.
// Optional feature: define COMP_CAPTURE_PARITY_EN to add data_par, the XOR
// reduction of data_out registered with the word.
module comp_capture
  import comp_capture_pkg::*;
#(
  parameter int NBITS = 12,
  parameter int SEQW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             conv_start,
  input  logic             comp_strobe,
  input  logic             comp_in,
  output logic [NBITS-1:0] data_out,
  output logic [SEQW-1:0]  data_seq,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [OVF_W-1:0] ovf_cnt,
  output logic             busy
`ifdef COMP_CAPTURE_PARITY_EN
  ,
  output logic             data_par
`endif
);

  localparam int CW = cnt_width(NBITS);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [NBITS-1:0] shift_q;
  logic [NBITS-1:0] shift_d;
  logic [SEQW-1:0]  tag_q;
  logic [NBITS-1:0] data_q;
  logic [SEQW-1:0]  seq_q;
  logic             valid_q;

  logic strobe_ok;
  logic word_done;
  logic word_load;
  logic word_drop;

  // A strobe counts only while collecting, enabled, and not overridden by a
  // simultaneous conv_start (which restarts the conversion instead).
  assign strobe_ok = enable && (state_q == COLLECT) && comp_strobe && !conv_start;
  assign word_done = strobe_ok && (cnt_q == CW'(NBITS - 1));
  assign shift_d   = {shift_q[NBITS-2:0], comp_in};
  // The single output slot accepts a word when empty or when it empties on
  // this same edge; otherwise the finished word is lost.
  assign word_load = word_done && (!valid_q || data_ready);
  assign word_drop = word_done && !word_load;

  // Sequencer: state, bit counter and decision shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (!enable) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (conv_start) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (strobe_ok) begin
      shift_q <= shift_d;
      if (word_done) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Sequence tag advances on every completed word, loaded or dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else if (word_done) begin
      tag_q <= tag_q + SEQW'(1);
    end
  end

  // One-entry output register; contents hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      seq_q   <= '0;
      valid_q <= 1'b0;
    end else if (word_load) begin
      data_q  <= shift_d;
      seq_q   <= tag_q;
      valid_q <= 1'b1;
    end else if (valid_q && data_ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef COMP_CAPTURE_PARITY_EN
  logic par_q;

  // Parity travels with the word so it always matches data_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (word_load) begin
      par_q <= ^shift_d;
    end
  end

  assign data_par = par_q;
`endif

  comp_capture_satcnt #(
    .W(OVF_W)
  ) u_ovf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (word_drop),
    .cnt_o (ovf_cnt)
  );

  assign data_out   = data_q;
  assign data_seq   = seq_q;
  assign data_valid = valid_q;
  assign busy       = (state_q == COLLECT);

endmodule

// File: tb/tb_comp_capture.sv
// Directed self-checking bench for comp_capture with a transfer scoreboard.
module tb_comp_capture;

  localparam int NBITS = 12;
  localparam int SEQW  = 4;

  typedef struct packed {
    logic [NBITS-1:0] data;
    logic [SEQW-1:0]  seq;
  } item_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             conv_start = 1'b0;
  logic             comp_strobe = 1'b0;
  logic             comp_in = 1'b0;
  logic             data_ready = 1'b0;
  logic [NBITS-1:0] data_out;
  logic [SEQW-1:0]  data_seq;
  logic             data_valid;
  logic [7:0]       ovf_cnt;
  logic             busy;
`ifdef COMP_CAPTURE_PARITY_EN
  logic             data_par;
`endif

  int    n_cmp = 0;
  int    n_err = 0;
  item_t sb[$];

  comp_capture #(
    .NBITS(NBITS),
    .SEQW (SEQW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .conv_start (conv_start),
    .comp_strobe(comp_strobe),
    .comp_in    (comp_in),
    .data_out   (data_out),
    .data_seq   (data_seq),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .ovf_cnt    (ovf_cnt),
    .busy       (busy)
`ifdef COMP_CAPTURE_PARITY_EN
    ,
    .data_par   (data_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a handshake is visible at the negedge before the transfer edge.
  always @(negedge clk) begin
    if (rst_n && data_valid && data_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        item_t exp_item;
        exp_item = sb.pop_front();
        check("sb_data", 32'(data_out), 32'(exp_item.data));
        check("sb_seq", 32'(data_seq), 32'(exp_item.seq));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b);
    comp_strobe = 1'b1;
    comp_in     = b;
    step();
    comp_strobe = 1'b0;
    comp_in     = 1'b0;
  endtask

  task automatic start();
    conv_start = 1'b1;
    step();
    conv_start = 1'b0;
  endtask

  task automatic convert(input logic [NBITS-1:0] w);
    start();
    for (int i = NBITS - 1; i >= 0; i--) strobe(w[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    conv_start = 1'b0;
    comp_strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [NBITS-1:0] w;

    // Reset values
    enable = 1'b1;
    data_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_data_seq", 32'(data_seq), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_ovf", 32'(ovf_cnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    step();

    // 1: basic capture, valid for exactly one cycle with ready high
    start();
    check("t1_busy_rise", 32'(busy), 32'h1);
    sb.push_back('{data: 12'hB0F, seq: 4'd0});
    w = 12'hB0F;
    for (int i = NBITS - 1; i >= 0; i--) strobe(w[i]);
    check("t1_valid", 32'(data_valid), 32'h1);
    check("t1_busy_fall", 32'(busy), 32'h0);
    check("t1_data", 32'(data_out), 32'hB0F);
    step();
    check("t1_valid_drop", 32'(data_valid), 32'h0);

    // 2: abort partial conversion with a fresh conv_start
    do_reset();
    start();
    for (int i = 0; i < 5; i++) strobe(i[0]);
    sb.push_back('{data: 12'hFFF, seq: 4'd0});
    convert(12'hFFF);
    check("t2_data", 32'(data_out), 32'hFFF);
    check("t2_seq", 32'(data_seq), 32'h0);
    step();
    check("t2_ovf", 32'(ovf_cnt), 32'h0);

    // 3: back-pressure, second and third words dropped
    do_reset();
    data_ready = 1'b0;
    sb.push_back('{data: 12'h123, seq: 4'd0});
    convert(12'h123);
    convert(12'h456);
    check("t3_hold_mid", 32'(data_out), 32'h123);
    convert(12'h789);
    check("t3_hold_data", 32'(data_out), 32'h123);
    check("t3_hold_seq", 32'(data_seq), 32'h0);
    check("t3_hold_valid", 32'(data_valid), 32'h1);
    check("t3_ovf", 32'(ovf_cnt), 32'd2);
    data_ready = 1'b1;
    step();
    check("t3_drained", 32'(data_valid), 32'h0);
    sb.push_back('{data: 12'hACE, seq: 4'd3});
    convert(12'hACE);
    check("t3_seq_gap", 32'(data_seq), 32'd3);
    step();
    check("t3_ovf_kept", 32'(ovf_cnt), 32'd2);

    // 4: simultaneous hand-off, then saturation of the drop counter
    do_reset();
    data_ready = 1'b0;
    sb.push_back('{data: 12'h3C3, seq: 4'd0});
    convert(12'h3C3);
    sb.push_back('{data: 12'h5A5, seq: 4'd1});
    w = 12'h5A5;
    start();
    for (int i = NBITS - 1; i >= 1; i--) strobe(w[i]);
    data_ready = 1'b1;
    strobe(w[0]);
    data_ready = 1'b0;
    check("t4_valid_stays", 32'(data_valid), 32'h1);
    check("t4_handoff_data", 32'(data_out), 32'h5A5);
    check("t4_handoff_seq", 32'(data_seq), 32'd1);
    check("t4_no_drop", 32'(ovf_cnt), 32'h0);
    for (int n = 0; n < 255; n++) convert(12'(n));
    step();
    check("t4_ovf_255", 32'(ovf_cnt), 32'd255);
    for (int n = 0; n < 45; n++) convert(12'(n));
    step();
    check("t4_ovf_sat", 32'(ovf_cnt), 32'd255);
    check("t4_held_data", 32'(data_out), 32'h5A5);
    data_ready = 1'b1;
    step();
    step();
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // 5: disable mid-conversion, ignored strobes/starts, async reset
    do_reset();
    start();
    for (int i = 0; i < 6; i++) strobe(1'b1);
    enable = 1'b0;
    step();
    check("t5_busy_off", 32'(busy), 32'h0);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) strobe(1'b1);
    check("t5_idle_strobe_busy", 32'(busy), 32'h0);
    check("t5_no_word", 32'(data_valid), 32'h0);
    enable = 1'b0;
    start();
    check("t5_start_ignored", 32'(busy), 32'h0);
    enable = 1'b1;
    data_ready = 1'b0;
    convert(12'h9C6);
    check("t5_word", 32'(data_out), 32'h9C6);
    check("t5_seq", 32'(data_seq), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_arst_valid", 32'(data_valid), 32'h0);
    check("t5_arst_data", 32'(data_out), 32'h0);
    check("t5_arst_seq", 32'(data_seq), 32'h0);
    check("t5_arst_ovf", 32'(ovf_cnt), 32'h0);
    check("t5_arst_busy", 32'(busy), 32'h0);
    data_ready = 1'b1;
    do_reset();

`ifdef COMP_CAPTURE_PARITY_EN
    // 6: parity travels with the word
    sb.push_back('{data: 12'hB0F, seq: 4'd0});
    convert(12'hB0F);
    check("t6_par_b0f", 32'(data_par), 32'h1);
    sb.push_back('{data: 12'hFFF, seq: 4'd1});
    convert(12'hFFF);
    check("t6_par_fff", 32'(data_par), 32'h0);
    step();
`endif

    step();
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
